// File: rtl/max_pool_engine_pkg.sv
// max_pool_engine_pkg: shared defines for the pooling engine (states, widths, opcodes, layer types)
package max_pool_engine_pkg;
  localparam int ADDR_W = 27;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] OP_CONV = 4'h1;
  localparam logic [3:0] OP_MAXPOOL = 4'h2;
  localparam logic [1:0] LT_CONV = 2'd0;
  localparam logic [1:0] LT_MAXPOOL = 2'd1;
  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, WWAIT, DRAIN, DONE} mp_state_t;
endpackage

// File: rtl/max_pool_engine_addr_gen.sv
// max_pool_engine_addr_gen: c/oh/ow/element counters and input/output word addresses
module max_pool_engine_addr_gen
  import max_pool_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              elem_step,
  input  logic              out_step,
  input  logic [ADDR_W-1:0] ifaddr,
  input  logic [ADDR_W-1:0] ofaddr,
  input  logic [10:0]       ch,
  input  logic [12:0]       h,
  input  logic [12:0]       w,
  output logic [1:0]        elem,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last
);
  logic [10:0] c;
  logic [11:0] oh, ow;
  logic [11:0] oh_n, ow_n;
  logic [ADDR_W-1:0] in_row, out_row;
  assign oh_n = h[12:1];
  assign ow_n = w[12:1];
  // all arithmetic stays 27 bits wide so addresses wrap modulo 2^27
  assign in_row = ADDR_W'(c) * ADDR_W'(h) + ADDR_W'({oh, elem[1]});
  assign in_addr = ifaddr + in_row * ADDR_W'(w) + ADDR_W'({ow, elem[0]});
  assign out_row = ADDR_W'(c) * ADDR_W'(oh_n) + ADDR_W'(oh);
  assign out_addr = ofaddr + out_row * ADDR_W'(ow_n) + ADDR_W'(ow);
  assign last = (c == ch - 11'd1) && (oh == oh_n - 12'd1) && (ow == ow_n - 12'd1);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      c <= '0;
      oh <= '0;
      ow <= '0;
      elem <= '0;
    end else if (out_step) begin
      elem <= '0;
      ow <= (ow == ow_n - 12'd1) ? '0 : ow + 12'd1;
      if (ow == ow_n - 12'd1) begin
        oh <= (oh == oh_n - 12'd1) ? '0 : oh + 12'd1;
        c <= (oh == oh_n - 12'd1) ? c + 11'd1 : c;
      end
    end else if (elem_step) begin
      elem <= elem + 2'd1;
    end
  end
endmodule

// File: rtl/max_pool_engine.sv
// max_pool_engine: 2x2 stride-2 max pooling over a C x H x W feature map in word memory
module max_pool_engine
  import max_pool_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mp_rst,
  input  logic [ADDR_W-1:0]        mp_ifaddr,
  input  logic [ADDR_W-1:0]        mp_ofaddr,
  input  logic [10:0]              cv_I,
  input  logic [12:0]              cv_H,
  input  logic [12:0]              cv_W,
  output logic                     mp_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd_req,
  input  logic                     mem_rd_valid,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic                     mem_wr_req,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_wr_ack
);
  mp_state_t state;
  logic [ADDR_W-1:0] if_q, of_q, in_addr, out_addr;
  logic [10:0] c_q;
  logic [12:0] h_q, w_q;
  logic signed [DATA_W-1:0] max_q;
  logic [1:0] elem;
  logic last, reading, start, drain_go, degen_in, degen_q, elem_step, out_step;
  assign degen_in = (cv_I == '0) || (cv_H < 13'd2) || (cv_W < 13'd2);
  assign degen_q = (c_q == '0) || (h_q < 13'd2) || (w_q < 13'd2);
  assign reading = (state == RWAIT) || (state == DRAIN);
  // a restart while a read is still outstanding must first swallow its response
  assign drain_go = mp_rst && reading && !mem_rd_valid;
  assign start = mp_rst && !drain_go;
  assign elem_step = (state == RWAIT) && mem_rd_valid;
  assign out_step = ((state == WR) || (state == WWAIT)) && mem_wr_ack && !last;
  assign mem_rd_req = (state == RD);
  assign mem_wr_req = (state == WR) || (state == WWAIT);
  assign mem_addr = mem_rd_req ? in_addr : mem_wr_req ? out_addr : '0;
  assign mem_wdata = mem_wr_req ? max_q : '0;
  max_pool_engine_addr_gen u_addr_gen (
    .clk(clk),
    .rst_n(rst_n),
    .clr(mp_rst),
    .elem_step(elem_step),
    .out_step(out_step),
    .ifaddr(if_q),
    .ofaddr(of_q),
    .ch(c_q),
    .h(h_q),
    .w(w_q),
    .elem(elem),
    .in_addr(in_addr),
    .out_addr(out_addr),
    .last(last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      if_q <= '0;
      of_q <= '0;
      c_q <= '0;
      h_q <= '0;
      w_q <= '0;
      max_q <= '0;
      mp_done <= 1'b0;
    end else begin
      mp_done <= 1'b0;
      if (mp_rst) begin
        if_q <= mp_ifaddr;
        of_q <= mp_ofaddr;
        c_q <= cv_I;
        h_q <= cv_H;
        w_q <= cv_W;
      end
      if (start) state <= degen_in ? DONE : RD;
      else if (drain_go) state <= DRAIN;
      else case (state)
        IDLE: state <= IDLE;
        RD: state <= RWAIT;
        RWAIT: if (mem_rd_valid) begin
          max_q <= (elem == 2'd0 || mem_rdata > max_q) ? mem_rdata : max_q;
          state <= (elem == 2'd3) ? WR : RD;
        end
        WR, WWAIT: if (mem_wr_ack) begin
          state <= last ? DONE : RD;
          mp_done <= last;
        end else state <= WWAIT;
        DRAIN: if (mem_rd_valid) state <= degen_q ? DONE : RD;
        // entered without a pending pulse (empty map) DONE lasts two cycles, pulsing in the second
        DONE: begin
          mp_done <= !mp_done;
          state <= mp_done ? IDLE : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_max_pool_engine.sv
// tb_max_pool_engine: randomized checks of max_pool_engine against a nested-loop pooling model
module tb_max_pool_engine;
  localparam int unsigned AM = 32'h07FF_FFFF;
  logic clk = 0, rst_n = 0, mp_rst = 0;
  logic [26:0] mp_ifaddr = 0, mp_ofaddr = 0;
  logic [10:0] cv_I = 0;
  logic [12:0] cv_H = 0, cv_W = 0;
  logic mp_done, mem_rd_req, mem_wr_req;
  logic [26:0] mem_addr;
  logic mem_rd_valid = 0, mem_wr_ack = 0;
  logic signed [15:0] mem_rdata = 0;
  logic [15:0] mem_wdata;
  max_pool_engine dut (
    .clk(clk), .rst_n(rst_n), .mp_rst(mp_rst), .mp_ifaddr(mp_ifaddr), .mp_ofaddr(mp_ofaddr),
    .cv_I(cv_I), .cv_H(cv_H), .cv_W(cv_W), .mp_done(mp_done), .mem_addr(mem_addr),
    .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] mem [int unsigned];
  int rd_delay = 1, wr_delay = 0, rd_cnt = 0, wcnt = 0, done_cnt = 0, done_cyc = 0, stab_bad = 0, wr_seen = 0;
  bit rd_pend = 0;
  int unsigned rd_a, rd_log[$], wa_log[$], exp_rd[$], exp_wa[$];
  logic [15:0] wd_log[$], exp_wd[$], w0_data;
  logic [26:0] w0_addr;
  function automatic logic [15:0] rd_val(int unsigned a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction
  // memory: reads answer rd_delay cycles after the request, writes ack after wr_delay extra cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 0; wcnt = 0; mem_rd_valid = 0; mem_wr_ack = 0;
    end else begin
      mem_rd_valid = 0; mem_wr_ack = 0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin mem_rd_valid = 1; mem_rdata = rd_val(rd_a); rd_pend = 0; end
        else rd_cnt--;
      end
      if (mem_rd_req) begin rd_pend = 1; rd_cnt = rd_delay - 1; rd_a = 32'(mem_addr); rd_log.push_back(32'(mem_addr)); end
      if (mem_wr_req) begin
        wr_seen++;
        if (wcnt == 0) begin w0_addr = mem_addr; w0_data = mem_wdata; end
        else if (mem_addr !== w0_addr || mem_wdata !== w0_data) stab_bad++;
        if (wcnt == wr_delay) begin
          mem_wr_ack = 1; wa_log.push_back(32'(mem_addr)); wd_log.push_back(mem_wdata); wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
      if (mp_done) begin done_cnt++; done_cyc = cyc; end
    end
  end
  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    done_cnt = 0; stab_bad = 0; wr_seen = 0;
  endtask
  task automatic fill(input int unsigned ifa, input int c, input int h, input int w);
    mem.delete();
    for (int i = 0; i < c * h * w; i++) mem[(ifa + i) & AM] = 16'($urandom);
  endtask
  task automatic model(input int unsigned ifa, input int unsigned ofa, input int c, input int h, input int w);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int ci = 0; ci < c; ci++)
      for (int oh = 0; oh < h / 2; oh++)
        for (int ow = 0; ow < w / 2; ow++) begin
          int m = -100000;
          for (int k = 0; k < 4; k++) begin
            int unsigned a = (ifa + (ci * h + 2 * oh + k / 2) * w + 2 * ow + k % 2) & AM;
            int v = $signed(rd_val(a));
            exp_rd.push_back(a);
            if (v > m) m = v;
          end
          exp_wa.push_back((ofa + (ci * (h / 2) + oh) * (w / 2) + ow) & AM);
          exp_wd.push_back(16'(m));
        end
  endtask
  task automatic start(input int unsigned ifa, input int unsigned ofa, input int c, input int h, input int w);
    @(negedge clk);
    mp_rst = 1; mp_ifaddr = 27'(ifa); mp_ofaddr = 27'(ofa);
    cv_I = 11'(c); cv_H = 13'(h); cv_W = 13'(w); t0 = cyc;
    @(negedge clk);
    mp_rst = 0; mp_ifaddr = 27'($urandom); mp_ofaddr = 27'($urandom);
    cv_I = 11'($urandom); cv_H = 13'($urandom); cv_W = 13'($urandom);
  endtask
  task automatic wait_done(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin @(negedge clk); ok = (done_cnt > 0); end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 0; mp_rst = 1; cv_I = 1; cv_H = 2; cv_W = 2;
    repeat (3) @(negedge clk);
    checks += 5;
    if (mp_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", mp_done); end
    if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b exp 0", mem_rd_req); end
    if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b exp 0", mem_wr_req); end
    if (mem_addr !== 27'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr); end
    if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", mem_wdata); end
    clear_logs();
    rst_n = 1; mp_rst = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (rd_log.size() != 0 || wr_seen != 0 || done_cnt != 0) begin
      errors++; $display("FAIL reset_idle: reads %0d writes %0d dones %0d exp 0 0 0", rd_log.size(), wr_seen, done_cnt);
    end
  endtask
  task automatic test_basic();
    int unsigned ofa = $urandom & AM;
    bit ok;
    clear_logs(); mem.delete(); rd_delay = 1; wr_delay = 0;
    mem[32'h100] = 16'd3; mem[32'h101] = 16'hFFF9; mem[32'h102] = 16'd9; mem[32'h103] = 16'd2;
    start(32'h100, ofa, 1, 2, 2);
    wait_done(100, ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL basic_timeout: no mp_done within 100 cycles"); end
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d exp 1", done_cnt); end
    if (done_cyc - t0 != 10) begin errors++; $display("FAIL basic_latency: got %0d exp 10", done_cyc - t0); end
    if (wa_log.size() != 1) begin errors++; $display("FAIL basic_writes: got %0d exp 1", wa_log.size()); end
    else begin
      if (wa_log[0] != ofa) begin errors++; $display("FAIL basic_waddr: got %h exp %h", wa_log[0], ofa); end
      if (wd_log[0] !== 16'd9) begin errors++; $display("FAIL basic_wdata: got %0d exp 9", $signed(wd_log[0])); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_log.size() || rd_log[i] != 32'h100 + i) begin errors++; $display("FAIL basic_raddr%0d: exp %h", i, 32'h100 + i); end
    end
  endtask
  task automatic test_odd_height();
    int unsigned ifa = $urandom & AM, ofa = $urandom & AM;
    bit ok;
    clear_logs(); rd_delay = 1; wr_delay = 0;
    fill(ifa, 2, 5, 4); model(ifa, ofa, 2, 5, 4);
    start(ifa, ofa, 2, 5, 4);
    wait_done(500, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL odd_timeout: no mp_done within 500 cycles"); end
    if (done_cyc - t0 != 73) begin errors++; $display("FAIL odd_latency: got %0d exp 73", done_cyc - t0); end
    if (wa_log.size() != 8) begin errors++; $display("FAIL odd_writes: got %0d exp 8", wa_log.size()); end
    if (rd_log.size() != exp_rd.size()) begin errors++; $display("FAIL odd_reads: got %0d exp %0d", rd_log.size(), exp_rd.size()); end
    for (int i = 0; i < 8 && i < wa_log.size(); i++) begin
      checks += 2;
      if (wa_log[i] != ((ofa + i) & AM)) begin errors++; $display("FAIL odd_waddr%0d: got %h exp %h", i, wa_log[i], (ofa + i) & AM); end
      if (wd_log[i] !== exp_wd[i]) begin errors++; $display("FAIL odd_wdata%0d: got %h exp %h", i, wd_log[i], exp_wd[i]); end
    end
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) begin
      checks += 2;
      if (rd_log[i] != exp_rd[i]) begin errors++; $display("FAIL odd_raddr%0d: got %h exp %h", i, rd_log[i], exp_rd[i]); end
      if (((((rd_log[i] - ifa) & AM) / 4) % 5) == 4) begin errors++; $display("FAIL odd_row4: read %h hit row 4", rd_log[i]); end
    end
  endtask
  task automatic test_negative();
    int unsigned ifa = $urandom & AM, ofa = $urandom & AM;
    bit ok;
    clear_logs(); mem.delete(); rd_delay = 1; wr_delay = 0;
    mem[ifa] = 16'hFFFF; mem[(ifa + 1) & AM] = 16'hFFFB; mem[(ifa + 2) & AM] = 16'hFFFD; mem[(ifa + 3) & AM] = 16'hFFFE;
    start(ifa, ofa, 1, 2, 2);
    wait_done(100, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL neg_timeout: no mp_done within 100 cycles"); end
    if (wd_log.size() != 1 || wd_log[0] !== 16'hFFFF) begin
      errors++; $display("FAIL neg_max: got %0d writes first %h exp one write ffff", wd_log.size(), wd_log.size() ? wd_log[0] : 16'h0);
    end
  endtask
  task automatic test_degenerate();
    int cfg[3][3] = '{'{1, 1, 4}, '{0, 4, 4}, '{2, 4, 1}};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      start($urandom & AM, $urandom & AM, cfg[k][0], cfg[k][1], cfg[k][2]);
      wait_done(50, ok);
      checks += 3;
      if (!ok || done_cnt != 1) begin errors++; $display("FAIL degen%0d_done: got %0d pulses exp 1", k, done_cnt); end
      if (done_cyc - t0 != 2) begin errors++; $display("FAIL degen%0d_latency: got %0d exp 2", k, done_cyc - t0); end
      if (rd_log.size() != 0 || wr_seen != 0) begin errors++; $display("FAIL degen%0d_mem: reads %0d writes %0d exp 0 0", k, rd_log.size(), wr_seen); end
    end
  endtask
  task automatic test_abort_rwait();
    int unsigned a = $urandom & AM, b = (a + 32'h1000) & AM, ofa = $urandom & AM;
    bit ok;
    clear_logs(); mem.delete(); rd_delay = 5; wr_delay = 0;
    for (int i = 0; i < 4; i++) begin
      mem[(a + i) & AM] = 16'h7000 + 16'(i);
      mem[(b + i) & AM] = 16'($urandom_range(0, 16'h0FFF));
    end
    model(b, ofa, 1, 2, 2);
    start(a, ofa, 1, 2, 2);
    start(b, ofa, 1, 2, 2);
    wait_done(400, ok);
    checks += 4;
    if (!ok || done_cnt != 1) begin errors++; $display("FAIL abort_done: got %0d pulses exp 1", done_cnt); end
    if (rd_log.size() != 5) begin errors++; $display("FAIL abort_reads: got %0d exp 5", rd_log.size()); end
    else if (rd_log[0] != a) begin errors++; $display("FAIL abort_first_read: got %h exp %h", rd_log[0], a); end
    if (wd_log.size() != 1 || wd_log[0] !== exp_wd[0]) begin
      errors++; $display("FAIL abort_wdata: got %0d writes first %h exp %h", wd_log.size(), wd_log.size() ? wd_log[0] : 16'h0, exp_wd[0]);
    end
    for (int i = 0; i < 4 && i + 1 < rd_log.size(); i++) begin
      checks++;
      if (rd_log[i + 1] != exp_rd[i]) begin errors++; $display("FAIL abort_raddr%0d: got %h exp %h", i, rd_log[i + 1], exp_rd[i]); end
    end
    rd_delay = 1;
  endtask
  task automatic test_wrap();
    int unsigned ifa = 32'h07FF_FFFE, ofa = $urandom & AM;
    bit ok;
    clear_logs(); rd_delay = 1; wr_delay = 3;
    fill(ifa, 1, 2, 2); model(ifa, ofa, 1, 2, 2);
    start(ifa, ofa, 1, 2, 2);
    wait_done(100, ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: no mp_done within 100 cycles"); end
    if (done_cyc - t0 != 13) begin errors++; $display("FAIL wrap_latency: got %0d exp 13", done_cyc - t0); end
    if (rd_log.size() != 4 || rd_log[2] != 0 || rd_log[3] != 1) begin
      errors++; $display("FAIL wrap_raddr: got %0d reads, third %h fourth %h exp 0 1", rd_log.size(), rd_log.size() > 2 ? rd_log[2] : 0, rd_log.size() > 3 ? rd_log[3] : 0);
    end
    if (stab_bad != 0) begin errors++; $display("FAIL wrap_stable: got %0d changes exp 0", stab_bad); end
    if (wd_log.size() != 1 || wd_log[0] !== exp_wd[0] || wa_log[0] != ofa) begin
      errors++; $display("FAIL wrap_write: got %0d writes first %h exp %h", wd_log.size(), wd_log.size() ? wd_log[0] : 16'h0, exp_wd[0]);
    end
    wr_delay = 0;
  endtask
  task automatic test_back_to_back();
    bit ok;
    for (int r = 0; r < 5; r++) begin
      int unsigned ifa = $urandom & AM, ofa = $urandom & AM;
      int c = $urandom_range(1, 3), h = $urandom_range(2, 7), w = $urandom_range(2, 7);
      clear_logs(); rd_delay = $urandom_range(1, 3); wr_delay = $urandom_range(0, 2);
      fill(ifa, c, h, w); model(ifa, ofa, c, h, w);
      start(ifa, ofa, c, h, w);
      wait_done(5000, ok);
      checks += 4;
      if (!ok || done_cnt != 1) begin errors++; $display("FAIL b2b%0d_done: got %0d pulses exp 1", r, done_cnt); end
      if (stab_bad != 0) begin errors++; $display("FAIL b2b%0d_stable: got %0d changes exp 0", r, stab_bad); end
      if (wa_log.size() != exp_wa.size()) begin errors++; $display("FAIL b2b%0d_writes: got %0d exp %0d", r, wa_log.size(), exp_wa.size()); end
      if (rd_log != exp_rd) begin errors++; $display("FAIL b2b%0d_reads: got %0d reads exp %0d (sequence differs)", r, rd_log.size(), exp_rd.size()); end
      for (int i = 0; i < wa_log.size() && i < exp_wa.size(); i++) begin
        checks++;
        if (wa_log[i] != exp_wa[i] || wd_log[i] !== exp_wd[i]) begin
          errors++; $display("FAIL b2b%0d_out%0d: got %h/%h exp %h/%h", r, i, wa_log[i], wd_log[i], exp_wa[i], exp_wd[i]);
        end
      end
    end
    rd_delay = 1; wr_delay = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_odd_height();
    test_negative();
    test_degenerate();
    test_abort_rwait();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
